// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_addsub
//  Description : Parametrised, pipelined carry-lookahead adder/subtractor.
//                WIDTH is split into STAGES equal slices of SW = WIDTH/STAGES
//                bits. Each slice is built from BLOCK-bit lookahead groups
//                that ripple into one another. The carry between slices is
//                registered, and the unconsumed upper operand slices travel
//                down the pipe next to it. One operation per clock is
//                streamed under a valid/ready handshake. The design reports
//                carry-out and signed overflow.
//
//  Parameters  : WIDTH  (32) operand/result width, multiple of STAGES*BLOCK
//                BLOCK  (4)  bits per lookahead group
//                STAGES (2)  pipeline stages, 1..8
//
//  Ports       : clk        in   rising-edge clock
//                rst        in   asynchronous reset, active-high
//                in_valid   in   operand beat valid
//                in_ready   out  beat accepted this cycle when in_valid=1
//                a, b       in   operands [WIDTH]
//                sub        in   1: a-b, 0: a+b+cin
//                cin        in   carry-in, ignored when sub=1
//                out_valid  out  result valid
//                out_ready  in   downstream accepts result
//                sum        out  result [WIDTH]
//                carry      out  carry out of MSB (sub: 1 = no borrow)
//                overflow   out  signed overflow
//
//  Config      : CLA_SAT_EN - when defined, sum saturates to the signed
//                max/min on overflow. This adds one output mux level and
//                does not change latency.
//
//  Revision    : 1.0  initial release
// ============================================================================
module cla_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int c_sw = WIDTH / STAGES;   // slice width
    localparam int c_ng = c_sw / BLOCK;     // lookahead groups per slice

    // ------------------------------------------------------------------
    // One BLOCK-bit lookahead group. Every internal carry is formed
    // directly from the generate/propagate terms and the group carry-in,
    // so no carry ripples inside the group. Returns {cout, sum}.
    // ------------------------------------------------------------------
    function automatic logic [BLOCK:0] cla_group(
        input logic [BLOCK-1:0] ga,
        input logic [BLOCK-1:0] gb,
        input logic             gc
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        g    = ga & gb;
        p    = ga ^ gb;
        c    = '0;
        c[0] = gc;
        for (int i = 0; i < BLOCK; i++) begin
            // The carry-in propagates through every bit up to i.
            term = gc;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c[i+1] = term;
            // Bit j generates and all bits above it, up to i, propagate.
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int l = j + 1; l <= i; l++) begin
                    term = term & p[l];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    // One slice: the lookahead groups ripple into each other. Returns {cout, sum}.
    function automatic logic [c_sw:0] slice_add(
        input logic [c_sw-1:0] sa,
        input logic [c_sw-1:0] sb,
        input logic            sc
    );
        logic [c_sw-1:0] s;
        logic            c;
        logic [BLOCK:0]  gr;
        s = '0;
        c = sc;
        for (int gi = 0; gi < c_ng; gi++) begin
            gr                  = cla_group(sa[gi*BLOCK +: BLOCK], sb[gi*BLOCK +: BLOCK], c);
            s[gi*BLOCK +: BLOCK] = gr[BLOCK-1:0];
            c                   = gr[BLOCK];
        end
        return {c, s};
    endfunction

    // Effective second operand. Subtraction is a + ~b + 1. The +1 comes in
    // through the slice-0 carry (sub|cin), which is why cin has no effect
    // when sub=1.
    logic [WIDTH-1:0]  w_bx;
    logic [STAGES-1:0] w_vld;

    assign w_bx = b ^ {WIDTH{sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unconsumed when the beat enters stage k.
        localparam int c_rw = WIDTH - k * c_sw;

        logic [c_rw-1:0]       w_opa;
        logic [c_rw-1:0]       w_opb;
        logic                  w_ci;
        logic                  w_vin;
        logic                  w_en;
        logic [c_sw:0]         w_add;
        logic [(k+1)*c_sw-1:0] w_res_nxt;

        logic                  r_valid;
        logic                  r_c;
        logic [(k+1)*c_sw-1:0] r_res;

        // Stage k can load unless it and every stage after it hold a beat
        // and the output is stalled. The terms are all registered, so the
        // ready chain has no combinational loop and leaves no bubble.
        assign w_en     = out_ready || !(&w_vld[STAGES-1:k]);
        assign w_vld[k] = r_valid;
        assign w_add    = slice_add(w_opa[c_sw-1:0], w_opb[c_sw-1:0], w_ci);

        if (k == 0) begin : g_src_in
            assign w_opa     = a;
            assign w_opb     = w_bx;
            assign w_ci      = sub | cin;
            assign w_vin     = in_valid;
            assign w_res_nxt = w_add[c_sw-1:0];
        end else begin : g_src_prev
            assign w_opa     = g_stage[k-1].g_keep.r_a;
            assign w_opb     = g_stage[k-1].g_keep.r_b;
            assign w_ci      = g_stage[k-1].r_c;
            assign w_vin     = g_stage[k-1].r_valid;
            assign w_res_nxt = {w_add[c_sw-1:0], g_stage[k-1].r_res};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_c     <= 1'b0;
                r_res   <= '0;
            end else if (w_en) begin
                r_valid <= w_vin;
                if (w_vin) begin
                    r_res <= w_res_nxt;
                    r_c   <= w_add[c_sw];
                end
            end
        end

        if (k < STAGES - 1) begin : g_keep
            // Skewed copy of the operand slices that later stages still need.
            logic [c_rw-c_sw-1:0] r_a;
            logic [c_rw-c_sw-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en && w_vin) begin
                    r_a <= w_opa[c_rw-1:c_sw];
                    r_b <= w_opb[c_rw-1:c_sw];
                end
            end
        end else begin : g_last
            // The MSB slice: overflow uses the operand signs after b has
            // been inverted for subtraction.
            logic r_ovf;
`ifdef CLA_SAT_EN
            logic r_asign;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
`ifdef CLA_SAT_EN
                    r_asign <= 1'b0;
`endif
                end else if (w_en && w_vin) begin
                    r_ovf <= (w_opa[c_sw-1] == w_opb[c_sw-1])
                          && (w_add[c_sw-1] != w_opa[c_sw-1]);
`ifdef CLA_SAT_EN
                    r_asign <= w_opa[c_sw-1];
`endif
                end
            end
        end
    end

    logic [WIDTH-1:0] w_sum_raw;

    assign in_ready  = g_stage[0].w_en;
    assign out_valid = g_stage[STAGES-1].r_valid;
    assign carry     = g_stage[STAGES-1].r_c;
    assign overflow  = g_stage[STAGES-1].g_last.r_ovf;
    assign w_sum_raw = g_stage[STAGES-1].r_res;

`ifdef CLA_SAT_EN
    localparam logic [WIDTH-1:0] c_sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_neg = {1'b1, {(WIDTH-1){1'b0}}};

    // Both operands have the same sign whenever overflow is set, so the
    // sign of a selects the saturation rail.
    assign sum = g_stage[STAGES-1].g_last.r_ovf
               ? (g_stage[STAGES-1].g_last.r_asign ? c_sat_neg : c_sat_pos)
               : w_sum_raw;
`else
    assign sum = w_sum_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_addsub
//  Description : Directed self-checking bench for cla_pipe_addsub.
//                The main instance uses the default configuration
//                (32/4/2). A second instance uses 64/8/4 to exercise
//                carries across several registered slice boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cla_pipe_addsub;

    localparam int STAGES = 2;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        sub, cin, carry, overflow;

    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] a64, b64, sum64;
    logic        sub64, cin64, carry64, overflow64;

    int total  = 0;
    int passed = 0;

    cla_pipe_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow)
    );

    cla_pipe_addsub #(.WIDTH(64), .BLOCK(8), .STAGES(4)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .sub(sub64), .cin(cin64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .sum(sum64), .carry(carry64), .overflow(overflow64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Final sum seen at the port: wrapped by default, saturated with CLA_SAT_EN.
    function automatic logic [31:0] fin32(input logic [31:0] s, input logic ov, input logic sa);
`ifdef CLA_SAT_EN
        if (ov) return sa ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return s;
    endfunction

    // Arithmetic reference for the random stream: {carry, overflow, sum}.
    function automatic logic [33:0] model32(input logic [31:0] ma, input logic [31:0] mb,
                                            input logic ms, input logic mc);
        logic [31:0] bb;
        logic [32:0] r;
        logic        ov;
        bb = ms ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bb} + {32'd0, (ms | mc)};
        ov = (ma[31] == bb[31]) && (r[31] != ma[31]);
        return {r[32], ov, fin32(r[31:0], ov, ma[31])};
    endfunction

    // One beat through the idle 32-bit pipe: exact latency, then the values.
    task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic ts, input logic tc,
                         input logic [31:0] esum, input logic ec, input logic eo);
        a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, 96'(in_ready), 96'(1'b1));
        step();
        in_valid = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            chk({tag, "_lat"}, 96'(out_valid), 96'(1'b0));
            step();
        end
        chk({tag, "_vld"}, 96'(out_valid), 96'(1'b1));
        chk(tag, 96'({carry, overflow, sum}), 96'({ec, eo, esum}));
        step();
    endtask

    task automatic run64(input string tag, input logic [63:0] ta, input logic [63:0] tb_,
                         input logic [63:0] esum, input logic ec, input logic eo);
        a64 = ta; b64 = tb_; sub64 = 1'b0; cin64 = 1'b0; in_valid64 = 1'b1;
        step();
        in_valid64 = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk({tag, "_lat"}, 96'(out_valid64), 96'(1'b0));
            step();
        end
        chk({tag, "_vld"}, 96'(out_valid64), 96'(1'b1));
        chk(tag, 96'({carry64, overflow64, sum64}), 96'({ec, eo, esum}));
        step();
    endtask

    initial begin
        logic [33:0] expq[$];
        logic [34:0] held;
        logic        stalled;
        logic [31:0] ra, rb;
        logic        rs, rc;
        int          nacc, ndrn, cyc;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        in_valid64 = 1'b0; a64 = '0; b64 = '0; sub64 = 1'b0; cin64 = 1'b0; out_ready64 = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", 96'(out_valid), 96'(1'b0));
        chk("rst_sum", 96'({carry, overflow, sum}), 96'(0));
        chk("rst_out_valid64", 96'(out_valid64), 96'(1'b0));
        chk("rst_sum64", 96'({carry64, overflow64, sum64}), 96'(0));
        rst = 1'b0;
        step();
        chk("rst_in_ready", 96'(in_ready), 96'(1'b1));

        // Directed vectors
        run32("wrap_all", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run32("pos_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, fin32(32'h8000_0000, 1'b1, 1'b0), 1'b0, 1'b1);
        run32("sub_borrow", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run32("sub_nobrw", 32'd7, 32'd5, 1'b1, 1'b0, 32'd2, 1'b1, 1'b0);
        run32("sub_cin", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
        run32("add_cin", 32'd1, 32'd2, 1'b0, 1'b1, 32'd4, 1'b0, 1'b0);
        run32("slice_cross", 32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        run32("neg_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, fin32(32'h7FFF_FFFF, 1'b1, 1'b1), 1'b1, 1'b1);
        run32("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 1'b0, fin32(32'h7FFF_FFFF, 1'b1, 1'b1), 1'b1, 1'b1);

        // Stall: fill both stages behind a stalled output, then drain in order.
        out_ready = 1'b0;
        a = 32'd1; b = 32'd1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        step();
        a = 32'd3; b = 32'd4;
        #1;
        chk("stall_fill_rdy", 96'(in_ready), 96'(1'b1));
        step();
        a = 32'd10; b = 32'd20;
        #1;
        chk("stall_full_rdy", 96'(in_ready), 96'(1'b0));
        chk("stall_head", 96'({out_valid, sum}), 96'({1'b1, 32'd2}));
        step();
        chk("stall_hold1", 96'({out_valid, in_ready, sum}), 96'({1'b1, 1'b0, 32'd2}));
        step();
        chk("stall_hold2", 96'({out_valid, in_ready, sum}), 96'({1'b1, 1'b0, 32'd2}));
        out_ready = 1'b1;
        #1;
        chk("stall_release_rdy", 96'(in_ready), 96'(1'b1));
        step();
        in_valid = 1'b0;
        chk("drain_b", 96'({out_valid, sum}), 96'({1'b1, 32'd7}));
        step();
        chk("drain_c", 96'({out_valid, sum}), 96'({1'b1, 32'd30}));
        step();
        chk("drain_empty", 96'(out_valid), 96'(1'b0));

        // Back-to-back stream with a pseudo-random output stall.
        nacc = 0; ndrn = 0; cyc = 0; stalled = 1'b0; held = '0;
        ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
        while (ndrn < 100 && cyc < 3000) begin
            in_valid  = (nacc < 100);
            a = ra; b = rb; sub = rs; cin = rc;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (stalled)
                chk("stream_hold", 96'({out_valid, carry, overflow, sum}), 96'(held));
            if (out_ready)
                chk("stream_rdy", 96'(in_ready), 96'(1'b1));
            if (out_valid && out_ready) begin
                if (expq.size() == 0)
                    chk("stream_extra", 96'(out_valid), 96'(1'b0));
                else
                    chk("stream_data", 96'({carry, overflow, sum}), 96'(expq.pop_front()));
                ndrn++;
            end
            stalled = out_valid && !out_ready;
            held    = {out_valid, carry, overflow, sum};
            if (in_valid && in_ready) begin
                expq.push_back(model32(ra, rb, rs, rc));
                nacc++;
                ra = $urandom; rb = $urandom;
                rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 96'(ndrn), 96'(100));
        step();
        chk("stream_empty", 96'(out_valid), 96'(1'b0));

        // Reset with two beats in flight.
        a = 32'd100; b = 32'd1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        step();
        a = 32'd200;
        step();
        in_valid = 1'b0;
        chk("inflight_vld", 96'(out_valid), 96'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("midrst_out", 96'({out_valid, carry, overflow, sum}), 96'(0));
        #2 rst = 1'b0;
        step();
        chk("no_stale1", 96'(out_valid), 96'(1'b0));
        step();
        chk("no_stale2", 96'(out_valid), 96'(1'b0));
        run32("post_rst", 32'd40, 32'd2, 1'b0, 1'b0, 32'd42, 1'b0, 1'b0);

        // 64-bit, 4-stage instance.
        run64("w64_cross", 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        run64("w64_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
